otp_ctrl_macro_arb: RTL and testbench
=====================================

# otp_ctrl_macro_arb

Arbiter and sequencer sharing the single OTP macro command port between `NumReq` partition-level requesters (DAI, LCI, buffered/unbuffered partitions) inside otp_ctrl. It locks the macro request to one winner until the macro grants it. It tracks issue order of outstanding commands so each macro response is routed back to the requester that issued it. It enters a terminal error state on escalation or on a protocol violation.

## Interface
- `NumReq`, default 4: number of requesters, 2..8.
- `MaxOutstanding`, default 2: maximum granted-but-unanswered macro commands, 1..4.

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `escalate_en_i`  in  lc_ctrl_pkg::lc_tx_t  escalation; loose-true forces the error state.
- `req_i`  in  NumReq  per-requester command request; held until the matching `gnt_o`.
- `cmd_i`  in  NumReq x prim_otp_pkg::cmd_e  per-requester command.
- `size_i`  in  NumReq x OtpSizeWidth  per-requester size.
- `wdata_i`  in  NumReq x OtpIfWidth  per-requester write data.
- `addr_i`  in  NumReq x OtpAddrWidth  per-requester address.
- `gnt_o`  out  NumReq  one-hot command accepted.
- `rvalid_o`  out  NumReq  one-hot response valid.
- `rdata_o`  out  ScrmblBlockWidth  broadcast response data.
- `err_o`  out  prim_otp_pkg::err_e  broadcast response error.
- `idle_o`  out  1  no locked request and no outstanding command.
- `fsm_err_o`  out  1  sticky fatal error.
- `otp_req_o`  out  1  macro request.
- `otp_cmd_o`  out  prim_otp_pkg::cmd_e  macro command.
- `otp_size_o`  out  OtpSizeWidth  macro size.
- `otp_wdata_o`  out  OtpIfWidth  macro write data.
- `otp_addr_o`  out  OtpAddrWidth  macro address.
- `otp_gnt_i`  in  1  macro grant.
- `otp_rvalid_i`  in  1  macro response valid.
- `otp_rdata_i`  in  ScrmblBlockWidth  macro response data.
- `otp_err_i`  in  prim_otp_pkg::err_e  macro response error.

## Operation
- FSM states `IdleSt`, `ReqSt`, `ErrorSt`. Sparse encoding, minimum Hamming distance 3, held in `PRIM_FLOP_SPARSE_FSM`. Any invalid encoding goes to `ErrorSt` and sets `fsm_err_o`.
- **IdleSt**: a requester is eligible when `req_i[i]=1` and the outstanding count is below `MaxOutstanding`. The winner is picked round-robin starting after the last granted index and registered into `owner_q`. Next state is `ReqSt`.
- **ReqSt**:
  - `otp_req_o=1`.
  - Macro command fields are muxed from requester `owner_q`; outside `ReqSt` they are driven to 0 / `Read`.
  - `gnt_o[owner_q] = otp_gnt_i`.
  - On `otp_gnt_i`: push `owner_q` into the owner FIFO (depth `MaxOutstanding`), update the round-robin pointer, and return to `IdleSt`.
  - The request is never withdrawn or re-arbitrated before the grant.
- **Responses**: on `otp_rvalid_i`, `rvalid_o[fifo head]=1` and the FIFO is popped. `rdata_o`/`err_o` pass through combinationally; they are valid only while some `rvalid_o` is high.
- **Outstanding count**:
  - +1 on grant, -1 on response.
  - Simultaneous grant and response leave it unchanged; push and pop in the same cycle are legal, including when the FIFO is full.
- **Protocol errors** (go to `ErrorSt`, set `fsm_err_o`):
  - `otp_rvalid_i` with an empty FIFO.
  - `otp_gnt_i` outside `ReqSt`.
- **Escalation**: loose-true `escalate_en_i` goes to `ErrorSt` from any state and sets `fsm_err_o`.
- **ErrorSt**: terminal.
  - `otp_req_o=0`, `gnt_o=0`, `rvalid_o=0`.
  - Pending responses are dropped.
  - Only reset exits this state.
- `idle_o = (state==IdleSt) && count==0`.

## Timing
- Reset values: state `IdleSt`, count 0, round-robin pointer points to requester 0 (wins first), `otp_req_o=0`, `gnt_o=0`, `rvalid_o=0`, `fsm_err_o=0`, `idle_o=1`.
- Arbitration latency: `req_i` high in cycle N gives `otp_req_o` high in cycle N+1.
- `gnt_o` and `rvalid_o` are combinational from `otp_gnt_i` and `otp_rvalid_i` (zero cycles).
- At least one `IdleSt` cycle separates consecutive grants: peak rate is one command every 2 cycles.
- Error entry: the `ErrorSt` outputs take effect the cycle after the trigger. `fsm_err_o` stays asserted from then until reset.
- Reset mid-operation clears the FIFO, count and lock immediately (asynchronous).

## Configuration
- `OTP_CTRL_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins. The round-robin pointer is removed.
- Undefined (default): round-robin as described above.

## Test plan
- **Single read**: `req_i[1]=1`, `addr_i[1]=0x10`.
  - Cycle 1: `otp_req_o=1`, `otp_addr_o=0x10`.
  - `otp_gnt_i` gives `gnt_o=4'b0010`.
  - A later `otp_rvalid_i` gives `rvalid_o=4'b0010`, then `idle_o=1`.
- **Fairness**: all 4 `req_i` held, macro grants immediately → grant order 0,1,2,3,0. With the macro defined → 0,0,0.
- **Outstanding limit**: `MaxOutstanding=2`, responses withheld.
  - After 2 grants `otp_req_o` stays 0.
  - The first `otp_rvalid_i` routes to the first owner; the third request issues 1 cycle later.
- **Simultaneous events**: count=1, then grant and response in the same cycle → count stays 1 and the next response routes to the newer owner.
- **Spurious response**: `otp_rvalid_i` with the FIFO empty → `fsm_err_o=1`; no further `otp_req_o` despite `req_i`.
- **Escalation in ReqSt**: `escalate_en_i=On` → next cycle `otp_req_o=0` and `fsm_err_o=1`; a subsequent `otp_rvalid_i` yields `rvalid_o=0`.

Source files
------------

// File: rtl/otp_ctrl_macro_arb.sv
// Shares the single OTP macro command port between NumReq requesters and routes each response back to its issuer.
// Define OTP_CTRL_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module otp_ctrl_macro_arb #(
    parameter int NumReq           = 4,
    parameter int MaxOutstanding   = 2,
    parameter int OtpCmdWidth      = 3,
    parameter int OtpErrWidth      = 3,
    parameter int OtpSizeWidth     = 2,
    parameter int OtpIfWidth       = 16,
    parameter int OtpAddrWidth     = 10,
    parameter int ScrmblBlockWidth = 64
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [3:0]                               escalate_en_i,
    input  logic [NumReq-1:0]                        req_i,
    input  logic [NumReq-1:0][OtpCmdWidth-1:0]       cmd_i,
    input  logic [NumReq-1:0][OtpSizeWidth-1:0]      size_i,
    input  logic [NumReq-1:0][OtpIfWidth-1:0]        wdata_i,
    input  logic [NumReq-1:0][OtpAddrWidth-1:0]      addr_i,
    output logic [NumReq-1:0]                        gnt_o,
    output logic [NumReq-1:0]                        rvalid_o,
    output logic [ScrmblBlockWidth-1:0]              rdata_o,
    output logic [OtpErrWidth-1:0]                   err_o,
    output logic                                     idle_o,
    output logic                                     fsm_err_o,
    output logic                                     otp_req_o,
    output logic [OtpCmdWidth-1:0]                   otp_cmd_o,
    output logic [OtpSizeWidth-1:0]                  otp_size_o,
    output logic [OtpIfWidth-1:0]                    otp_wdata_o,
    output logic [OtpAddrWidth-1:0]                  otp_addr_o,
    input  logic                                     otp_gnt_i,
    input  logic                                     otp_rvalid_i,
    input  logic [ScrmblBlockWidth-1:0]              otp_rdata_i,
    input  logic [OtpErrWidth-1:0]                   otp_err_i
);

    localparam logic [3:0]             LcTxOff = 4'b1010;
    localparam logic [OtpCmdWidth-1:0] CmdRead = '0;
    localparam int OwnW = $clog2(NumReq);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);

    // Pairwise Hamming distance of at least 3 between the legal encodings.
    typedef enum logic [4:0] {
        IdleSt  = 5'b00111,
        ReqSt   = 5'b11100,
        ErrorSt = 5'b11011
    } state_e;

    state_e            r_state, w_state_d;
    logic [OwnW-1:0]   r_owner, w_winner;
    logic              w_found;
    logic [OwnW-1:0]   r_fifo [MaxOutstanding];
    logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CntW-1:0]   r_cnt, w_cnt_avail;
    logic              w_active, w_esc, w_push, w_pop, w_spurious, w_bad_gnt, w_any_elig;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign w_active    = (r_state == IdleSt) || (r_state == ReqSt);
    assign w_esc       = (escalate_en_i != LcTxOff);
    assign w_push      = (r_state == ReqSt) && otp_gnt_i;
    assign w_pop       = w_active && otp_rvalid_i && (r_cnt != '0);
    assign w_spurious  = w_active && otp_rvalid_i && (r_cnt == '0);
    assign w_bad_gnt   = (r_state == IdleSt) && otp_gnt_i;
    // A response retiring this cycle frees its slot for the arbitration happening in the same cycle.
    assign w_cnt_avail = r_cnt - CntW'(w_pop);
    assign w_any_elig  = (|req_i) && (w_cnt_avail < CntW'(MaxOutstanding));

`ifdef OTP_CTRL_ARB_FIXED_PRIO_EN
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (!w_found && req_i[i]) begin
                w_winner = OwnW'(i);
                w_found  = 1'b1;
            end
        end
    end
`else
    logic [OwnW-1:0] r_rr_ptr;
    logic [OwnW-1:0] w_idx;

    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < NumReq; k++) begin
            w_idx = OwnW'((int'(r_rr_ptr) + k) % NumReq);
            if (!w_found && req_i[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
        end else if (w_push) begin
            r_rr_ptr <= (r_owner == OwnW'(NumReq - 1)) ? '0 : r_owner + OwnW'(1);
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IdleSt;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IdleSt: begin
                if (w_esc || w_bad_gnt || w_spurious) w_state_d = ErrorSt;
                else if (w_any_elig)                  w_state_d = ReqSt;
            end
            ReqSt: begin
                if (w_esc || w_spurious) w_state_d = ErrorSt;
                else if (otp_gnt_i)      w_state_d = IdleSt;
            end
            ErrorSt: w_state_d = ErrorSt;
            default: w_state_d = ErrorSt;
        endcase
    end

    always_comb begin
        otp_req_o   = 1'b0;
        otp_cmd_o   = CmdRead;
        otp_size_o  = '0;
        otp_wdata_o = '0;
        otp_addr_o  = '0;
        gnt_o       = '0;
        rvalid_o    = '0;
        if (r_state == ReqSt) begin
            otp_req_o      = 1'b1;
            otp_cmd_o      = cmd_i[r_owner];
            otp_size_o     = size_i[r_owner];
            otp_wdata_o    = wdata_i[r_owner];
            otp_addr_o     = addr_i[r_owner];
            gnt_o[r_owner] = otp_gnt_i;
        end
        if (w_pop) begin
            rvalid_o[r_fifo[r_rd_ptr]] = 1'b1;
        end
    end

    assign rdata_o   = otp_rdata_i;
    assign err_o     = otp_err_i;
    assign fsm_err_o = !w_active;
    assign idle_o    = (r_state == IdleSt) && (r_cnt == '0);

    // Owner lock plus the issue-order FIFO that maps responses back to requesters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if ((r_state == IdleSt) && w_any_elig) begin
                r_owner <= w_winner;
            end
            if (w_push) begin
                r_fifo[r_wr_ptr] <= r_owner;
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CntW'(1);
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_otp_ctrl_macro_arb.sv
// Directed testbench for otp_ctrl_macro_arb (NumReq=4, MaxOutstanding=2).
module tb_otp_ctrl_macro_arb;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic [3:0]            escalate_en_i;
    logic [3:0]            req_i;
    logic [3:0][2:0]       cmd_i;
    logic [3:0][1:0]       size_i;
    logic [3:0][15:0]      wdata_i;
    logic [3:0][9:0]       addr_i;
    logic [3:0]            gnt_o, rvalid_o;
    logic [63:0]           rdata_o;
    logic [2:0]            err_o;
    logic                  idle_o, fsm_err_o, otp_req_o;
    logic [2:0]            otp_cmd_o;
    logic [1:0]            otp_size_o;
    logic [15:0]           otp_wdata_o;
    logic [9:0]            otp_addr_o;
    logic                  otp_gnt_i, otp_rvalid_i;
    logic [63:0]           otp_rdata_i;
    logic [2:0]            otp_err_i;

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] LcOn  = 4'b0101;
    localparam logic [3:0] LcOff = 4'b1010;

    always #5 clk_i = ~clk_i;

    otp_ctrl_macro_arb dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .escalate_en_i(escalate_en_i),
        .req_i(req_i), .cmd_i(cmd_i), .size_i(size_i), .wdata_i(wdata_i), .addr_i(addr_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .idle_o(idle_o), .fsm_err_o(fsm_err_o),
        .otp_req_o(otp_req_o), .otp_cmd_o(otp_cmd_o), .otp_size_o(otp_size_o),
        .otp_wdata_o(otp_wdata_o), .otp_addr_o(otp_addr_o),
        .otp_gnt_i(otp_gnt_i), .otp_rvalid_i(otp_rvalid_i),
        .otp_rdata_i(otp_rdata_i), .otp_err_i(otp_err_i)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        rst_ni = 1'b0;
        escalate_en_i = LcOff;
        req_i = '0; cmd_i = '0; size_i = '0; wdata_i = '0; addr_i = '0;
        otp_gnt_i = 1'b0; otp_rvalid_i = 1'b0; otp_rdata_i = '0; otp_err_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        req_i = 4'b0001;
        tick();
        rst_ni = 1'b0;
        #1;
        total++; if (otp_req_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_otp_req: got %b exp 0", otp_req_o); end
        total++; if (gnt_o !== 4'b0000) begin bad++; $display("[TB] FAIL reset_gnt: got %b exp 0000", gnt_o); end
        total++; if (rvalid_o !== 4'b0000) begin bad++; $display("[TB] FAIL reset_rvalid: got %b exp 0000", rvalid_o); end
        total++; if (fsm_err_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_fsm_err: got %b exp 0", fsm_err_o); end
        total++; if (idle_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_idle: got %b exp 1", idle_o); end
        req_i = '0;
    endtask

    task automatic test_single_read;
        do_reset();
        req_i = 4'b0010;
        addr_i[1] = 10'h010;
        tick();
        total++; if (otp_req_o !== 1'b1) begin bad++; $display("[TB] FAIL single_otp_req: got %b exp 1", otp_req_o); end
        total++; if (otp_addr_o !== 10'h010) begin bad++; $display("[TB] FAIL single_addr: got %h exp 010", otp_addr_o); end
        total++; if (otp_cmd_o !== 3'd0) begin bad++; $display("[TB] FAIL single_cmd: got %h exp 0", otp_cmd_o); end
        otp_gnt_i = 1'b1;
        #1;
        total++; if (gnt_o !== 4'b0010) begin bad++; $display("[TB] FAIL single_gnt: got %b exp 0010", gnt_o); end
        tick();
        otp_gnt_i = 1'b0;
        req_i = '0;
        #1;
        total++; if (idle_o !== 1'b0) begin bad++; $display("[TB] FAIL single_busy: got %b exp 0", idle_o); end
        tick();
        otp_rvalid_i = 1'b1;
        otp_rdata_i = 64'hDEAD_BEEF_0123_4567;
        otp_err_i = 3'd2;
        #1;
        total++; if (rvalid_o !== 4'b0010) begin bad++; $display("[TB] FAIL single_rvalid: got %b exp 0010", rvalid_o); end
        total++; if (rdata_o !== 64'hDEAD_BEEF_0123_4567) begin bad++; $display("[TB] FAIL single_rdata: got %h exp deadbeef01234567", rdata_o); end
        total++; if (err_o !== 3'd2) begin bad++; $display("[TB] FAIL single_err: got %0d exp 2", err_o); end
        tick();
        otp_rvalid_i = 1'b0;
        #1;
        total++; if (idle_o !== 1'b1) begin bad++; $display("[TB] FAIL single_idle: got %b exp 1", idle_o); end
        total++; if (otp_addr_o !== 10'h000) begin bad++; $display("[TB] FAIL single_addr_idle: got %h exp 000", otp_addr_o); end
    endtask

    task automatic test_fairness;
        logic [3:0] exp_gnt, prev_gnt;
`ifdef OTP_CTRL_ARB_FIXED_PRIO_EN
        int order [5] = '{0, 0, 0, 0, 0};
`else
        int order [5] = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        req_i = 4'b1111;
        prev_gnt = '0;
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << order[k];
            tick();
            total++; if (otp_req_o !== 1'b1) begin bad++; $display("[TB] FAIL fair_req_%0d: got %b exp 1", k, otp_req_o); end
            otp_gnt_i = 1'b1;
            otp_rvalid_i = (k > 0);
            #1;
            total++; if (gnt_o !== exp_gnt) begin bad++; $display("[TB] FAIL fair_gnt_%0d: got %b exp %b", k, gnt_o, exp_gnt); end
            if (k > 0) begin
                total++; if (rvalid_o !== prev_gnt) begin bad++; $display("[TB] FAIL fair_rvalid_%0d: got %b exp %b", k, rvalid_o, prev_gnt); end
            end
            prev_gnt = exp_gnt;
            tick();
            otp_gnt_i = 1'b0;
            otp_rvalid_i = 1'b0;
        end
        req_i = '0;
    endtask

    task automatic test_outstanding_limit;
        do_reset();
        req_i = 4'b0111;
        cmd_i[2] = 3'd1; size_i[2] = 2'd1; wdata_i[2] = 16'hBEEF; addr_i[2] = 10'h155;
        tick();
        otp_gnt_i = 1'b1;
        #1;
        total++; if (gnt_o !== 4'b0001) begin bad++; $display("[TB] FAIL lim_gnt0: got %b exp 0001", gnt_o); end
        tick();
        otp_gnt_i = 1'b0;
        req_i = 4'b0110;
        tick();
        otp_gnt_i = 1'b1;
        #1;
        total++; if (gnt_o !== 4'b0010) begin bad++; $display("[TB] FAIL lim_gnt1: got %b exp 0010", gnt_o); end
        tick();
        otp_gnt_i = 1'b0;
        req_i = 4'b0100;
        tick();
        total++; if (otp_req_o !== 1'b0) begin bad++; $display("[TB] FAIL lim_blocked_a: got %b exp 0", otp_req_o); end
        tick();
        total++; if (otp_req_o !== 1'b0) begin bad++; $display("[TB] FAIL lim_blocked_b: got %b exp 0", otp_req_o); end
        otp_rvalid_i = 1'b1;
        #1;
        total++; if (rvalid_o !== 4'b0001) begin bad++; $display("[TB] FAIL lim_rvalid_first: got %b exp 0001", rvalid_o); end
        tick();
        otp_rvalid_i = 1'b0;
        #1;
        total++; if (otp_req_o !== 1'b1) begin bad++; $display("[TB] FAIL lim_third_req: got %b exp 1", otp_req_o); end
        total++; if (otp_cmd_o !== 3'd1) begin bad++; $display("[TB] FAIL lim_cmd: got %0d exp 1", otp_cmd_o); end
        total++; if (otp_size_o !== 2'd1) begin bad++; $display("[TB] FAIL lim_size: got %0d exp 1", otp_size_o); end
        total++; if (otp_wdata_o !== 16'hBEEF) begin bad++; $display("[TB] FAIL lim_wdata: got %h exp beef", otp_wdata_o); end
        total++; if (otp_addr_o !== 10'h155) begin bad++; $display("[TB] FAIL lim_addr: got %h exp 155", otp_addr_o); end
        otp_gnt_i = 1'b1;
        #1;
        total++; if (gnt_o !== 4'b0100) begin bad++; $display("[TB] FAIL lim_gnt2: got %b exp 0100", gnt_o); end
        tick();
        otp_gnt_i = 1'b0;
        req_i = '0;
    endtask

    task automatic test_simultaneous;
        do_reset();
        req_i = 4'b0001;
        tick();
        otp_gnt_i = 1'b1;
        tick();
        otp_gnt_i = 1'b0;
        req_i = 4'b0010;
        tick();
        otp_gnt_i = 1'b1;
        otp_rvalid_i = 1'b1;
        #1;
        total++; if (gnt_o !== 4'b0010) begin bad++; $display("[TB] FAIL sim_gnt: got %b exp 0010", gnt_o); end
        total++; if (rvalid_o !== 4'b0001) begin bad++; $display("[TB] FAIL sim_rvalid_old: got %b exp 0001", rvalid_o); end
        tick();
        otp_gnt_i = 1'b0;
        otp_rvalid_i = 1'b0;
        req_i = '0;
        #1;
        total++; if (idle_o !== 1'b0) begin bad++; $display("[TB] FAIL sim_count_nonzero: got %b exp 0", idle_o); end
        tick();
        otp_rvalid_i = 1'b1;
        #1;
        total++; if (rvalid_o !== 4'b0010) begin bad++; $display("[TB] FAIL sim_rvalid_new: got %b exp 0010", rvalid_o); end
        tick();
        otp_rvalid_i = 1'b0;
        #1;
        total++; if (idle_o !== 1'b1) begin bad++; $display("[TB] FAIL sim_idle: got %b exp 1", idle_o); end
        total++; if (fsm_err_o !== 1'b0) begin bad++; $display("[TB] FAIL sim_no_err: got %b exp 0", fsm_err_o); end
    endtask

    task automatic test_spurious;
        do_reset();
        otp_rvalid_i = 1'b1;
        tick();
        otp_rvalid_i = 1'b0;
        total++; if (fsm_err_o !== 1'b1) begin bad++; $display("[TB] FAIL spur_fsm_err: got %b exp 1", fsm_err_o); end
        req_i = 4'b1111;
        tick();
        tick();
        total++; if (otp_req_o !== 1'b0) begin bad++; $display("[TB] FAIL spur_no_req: got %b exp 0", otp_req_o); end
        total++; if (idle_o !== 1'b0) begin bad++; $display("[TB] FAIL spur_idle: got %b exp 0", idle_o); end
        req_i = '0;
    endtask

    task automatic test_bad_grant;
        do_reset();
        otp_gnt_i = 1'b1;
        #1;
        total++; if (gnt_o !== 4'b0000) begin bad++; $display("[TB] FAIL badgnt_gnt: got %b exp 0000", gnt_o); end
        tick();
        otp_gnt_i = 1'b0;
        total++; if (fsm_err_o !== 1'b1) begin bad++; $display("[TB] FAIL badgnt_fsm_err: got %b exp 1", fsm_err_o); end
    endtask

    task automatic test_escalation;
        do_reset();
        req_i = 4'b0001;
        tick();
        total++; if (otp_req_o !== 1'b1) begin bad++; $display("[TB] FAIL esc_pre_req: got %b exp 1", otp_req_o); end
        escalate_en_i = LcOn;
        tick();
        escalate_en_i = LcOff;
        total++; if (otp_req_o !== 1'b0) begin bad++; $display("[TB] FAIL esc_req: got %b exp 0", otp_req_o); end
        total++; if (fsm_err_o !== 1'b1) begin bad++; $display("[TB] FAIL esc_fsm_err: got %b exp 1", fsm_err_o); end
        otp_rvalid_i = 1'b1;
        otp_gnt_i = 1'b1;
        #1;
        total++; if (rvalid_o !== 4'b0000) begin bad++; $display("[TB] FAIL esc_rvalid: got %b exp 0000", rvalid_o); end
        total++; if (gnt_o !== 4'b0000) begin bad++; $display("[TB] FAIL esc_gnt: got %b exp 0000", gnt_o); end
        tick();
        otp_rvalid_i = 1'b0;
        otp_gnt_i = 1'b0;
        tick();
        total++; if (fsm_err_o !== 1'b1) begin bad++; $display("[TB] FAIL esc_sticky: got %b exp 1", fsm_err_o); end
        req_i = '0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_outstanding_limit();
        test_simultaneous();
        test_spurious();
        test_bad_grant();
        test_escalation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
